// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Purpose:
//    Control side of EX-stage operand forwarding for a classic 5-stage
//    in-order pipeline. A shadow copy of destination-register metadata
//    follows each instruction through ID/EX and EX/MEM. From it the block
//    works out three things:
//    - the registered 4:1 mux selects for EX operands A and B;
//    - a combinational load-use stall for PC and IF/ID;
//    - bubble insertion into ID/EX.
//    It also keeps a saturating count of stall cycles for performance
//    monitoring.
//
//    Select encoding (fixed):
//       00 = register-file operand
//       01 = MEM/WB writeback value
//       10 = EX/MEM ALU result
//       11 = reserved, never driven
//
// Parameters:
//    REG_AW  register-address width
//    CNT_W   stall-counter width
//
// Ports:
//    clk            system clock, rising-edge active
//    rst            asynchronous active-high reset
//    i_id_valid     ID stage holds a real instruction
//    i_id_rs1/rs2   source registers of the ID instruction
//    i_id_use_rs1/2 ID instruction actually reads rs1 / rs2
//    i_id_rd        destination register of the ID instruction
//    i_id_regwrite  ID instruction writes rd
//    i_id_memread   ID instruction is a load
//    i_flush        taken branch/jump in EX, kills the ID instruction
//    o_fwd_a_sel    operand-A select for the instruction now in EX (registered)
//    o_fwd_b_sel    operand-B select for the instruction now in EX (registered)
//    o_stall_id     hold PC and IF/ID this cycle (combinational)
//    o_ex_bubble    the instruction now in EX is a bubble (registered)
//    o_stall_count  saturating number of stall cycles since reset
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic              i_id_regwrite,
   input  logic              i_id_memread,
   input  logic              i_flush,
   output logic [1:0]        o_fwd_a_sel,
   output logic [1:0]        o_fwd_b_sel,
   output logic              o_stall_id,
   output logic              o_ex_bubble,
   output logic [CNT_W-1:0]  o_stall_count
);

   localparam logic [1:0] SEL_RF    = 2'b00;
   localparam logic [1:0] SEL_WB    = 2'b01;
   localparam logic [1:0] SEL_EXMEM = 2'b10;

   // Metadata carried alongside the instruction sitting in EX.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } idExT;

   // One stage further on, only the producer identity still matters:
   // a load here has its data ready by writeback, so it forwards like
   // any other producer.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              regwrite;
   } exMemT;

   localparam idExT  ID_EX_BUBBLE  = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};
   localparam exMemT EX_MEM_BUBBLE = '{rd: '0, regwrite: 1'b0};

   idExT             r_idEx;
   exMemT            r_exMem;
   logic [1:0]       r_fwdASel;
   logic [1:0]       r_fwdBSel;
   logic [CNT_W-1:0] r_stallCount;

   logic             w_hazard;
   logic             w_stall;
   logic             w_insertBubble;
   logic [1:0]       w_fwdASel;
   logic [1:0]       w_fwdBSel;
   idExT             w_idExNext;

   // Select for one operand of the instruction that will enter EX at the
   // next edge. The instruction now in ID/EX will be in EX/MEM by then, so
   // it is the newest producer and wins over EX/MEM, which will have moved
   // on to MEM/WB. x0 is hard-wired zero and is never forwarded. A producer
   // further back than that is already in the write-through register file.
   function automatic logic [1:0] selectFor(
      input logic              useRs,
      input logic [REG_AW-1:0] rs,
      input idExT              idEx,
      input exMemT             exMem
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (useRs && (rs != '0)) begin
         if (idEx.regwrite && (idEx.rd == rs)) begin
            sel = SEL_EXMEM;
         end else if (exMem.regwrite && (exMem.rd == rs)) begin
            sel = SEL_WB;
         end
      end
      return sel;
   endfunction

   // Hazard detection and next-state of the ID/EX shadow stage.
   // A load in ID/EX cannot feed its very next consumer, so that consumer
   // is held in ID for one cycle while a bubble goes into EX. A taken
   // branch takes precedence over the stall: the stalled instruction is
   // being killed anyway. Whenever ID/EX receives a bubble, the registered
   // selects for it fall back to the register file.
   always_comb begin
      w_hazard       = 1'b0;
      w_stall        = 1'b0;
      w_insertBubble = 1'b0;
      w_fwdASel      = SEL_RF;
      w_fwdBSel      = SEL_RF;
      w_idExNext     = ID_EX_BUBBLE;

      w_hazard = i_id_valid && r_idEx.memread && (r_idEx.rd != '0) &&
                 ((i_id_use_rs1 && (i_id_rs1 == r_idEx.rd)) ||
                  (i_id_use_rs2 && (i_id_rs2 == r_idEx.rd)));
      w_stall        = w_hazard && !i_flush;
      w_insertBubble = i_flush || w_stall || !i_id_valid;

      if (!w_insertBubble) begin
         w_fwdASel  = selectFor(i_id_use_rs1, i_id_rs1, r_idEx, r_exMem);
         w_fwdBSel  = selectFor(i_id_use_rs2, i_id_rs2, r_idEx, r_exMem);
         w_idExNext = '{valid:    1'b1,
                        rd:       i_id_rd,
                        regwrite: i_id_regwrite,
                        memread:  i_id_memread};
      end
   end

   // Shadow pipeline advance. The selects are captured on the same edge
   // that moves the instruction into EX, so they stay stable for its whole
   // EX cycle. Reset empties the pipeline immediately, which also makes
   // the current EX slot read as a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idEx    <= ID_EX_BUBBLE;
         r_exMem   <= EX_MEM_BUBBLE;
         r_fwdASel <= SEL_RF;
         r_fwdBSel <= SEL_RF;
      end else begin
         r_exMem   <= '{rd: r_idEx.rd, regwrite: r_idEx.regwrite};
         r_idEx    <= w_idExNext;
         r_fwdASel <= w_fwdASel;
         r_fwdBSel <= w_fwdBSel;
      end
   end

   // Stall-cycle counter for performance monitoring. It sticks at
   // all-ones instead of wrapping, so an overflowed count stays
   // recognisable. Only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCount <= '0;
      end else if (w_stall && (r_stallCount != '1)) begin
         r_stallCount <= r_stallCount + CNT_W'(1);
      end
   end

   // Output mapping. The bubble flag comes straight from the ID/EX shadow
   // register, so it is registered like the selects.
   assign o_fwd_a_sel   = r_fwdASel;
   assign o_fwd_b_sel   = r_fwdBSel;
   assign o_stall_id    = w_stall;
   assign o_ex_bubble   = !r_idEx.valid;
   assign o_stall_count = r_stallCount;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Purpose:
//    Directed scoreboard bench for fwd_hazard_ctrl. It is built with
//    CNT_W=4 so that stall-counter saturation can be reached quickly.
//
//    Each call to applyStimulus drives one cycle of ID-stage inputs and
//    pushes the hand-computed outputs expected during that same cycle.
//    An independent monitor pops one expectation per falling edge and
//    compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              idValid;
   logic [REG_AW-1:0] idRs1;
   logic [REG_AW-1:0] idRs2;
   logic              idUseRs1;
   logic              idUseRs2;
   logic [REG_AW-1:0] idRd;
   logic              idRegwrite;
   logic              idMemread;
   logic              flush;
   logic [1:0]        fwdASel;
   logic [1:0]        fwdBSel;
   logic              stallId;
   logic              exBubble;
   logic [CNT_W-1:0]  stallCount;

   typedef struct packed {
      int               id;
      logic [1:0]       fwdA;
      logic [1:0]       fwdB;
      logic             bubble;
      logic             stall;
      logic [CNT_W-1:0] count;
   } expT;

   expT expQ[$];
   expT monE;
   int  assertions = 0;
   int  failures   = 0;
   int  vecId      = 0;

   fwd_hazard_ctrl #(
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_id_valid    (idValid),
      .i_id_rs1      (idRs1),
      .i_id_rs2      (idRs2),
      .i_id_use_rs1  (idUseRs1),
      .i_id_use_rs2  (idUseRs2),
      .i_id_rd       (idRd),
      .i_id_regwrite (idRegwrite),
      .i_id_memread  (idMemread),
      .i_flush       (flush),
      .o_fwd_a_sel   (fwdASel),
      .o_fwd_b_sel   (fwdBSel),
      .o_stall_id    (stallId),
      .o_ex_bubble   (exBubble),
      .o_stall_count (stallCount)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison. Every call counts as an evaluated assertion.
   task automatic checkOutput(input int id, input string name, input int act, input int expv);
      assertions++;
      if (act != expv) begin
         failures++;
         $display("[TB] FAIL vec%0d %s: got %0d expected %0d", id, name, act, expv);
      end
   endtask

   // Monitor: on every falling edge, if stimulus has queued an expectation
   // for this cycle, pop it and compare all outputs.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput(monE.id, "fwd_a_sel",   int'(fwdASel),    int'(monE.fwdA));
         checkOutput(monE.id, "fwd_b_sel",   int'(fwdBSel),    int'(monE.fwdB));
         checkOutput(monE.id, "ex_bubble",   int'(exBubble),   int'(monE.bubble));
         checkOutput(monE.id, "stall_id",    int'(stallId),    int'(monE.stall));
         checkOutput(monE.id, "stall_count", int'(stallCount), int'(monE.count));
      end
   end

   // One cycle of stimulus. Inputs change 1 unit after the rising edge;
   // rst is updated 1 unit later, so a reset can land mid-cycle. The
   // expectation for the outputs seen later in this cycle is then queued.
   task automatic applyStimulus(
      input logic              rstVal,
      input logic              v,
      input logic [REG_AW-1:0] rs1,
      input logic              u1,
      input logic [REG_AW-1:0] rs2,
      input logic              u2,
      input logic [REG_AW-1:0] rd,
      input logic              rw,
      input logic              mr,
      input logic              fl,
      input logic [1:0]        ea,
      input logic [1:0]        eb,
      input logic              eBub,
      input logic              eSt,
      input int                eCnt
   );
      expT e;
      @(posedge clk);
      #1;
      idValid    = v;
      idRs1      = rs1;
      idUseRs1   = u1;
      idRs2      = rs2;
      idUseRs2   = u2;
      idRd       = rd;
      idRegwrite = rw;
      idMemread  = mr;
      flush      = fl;
      #1;
      rst = rstVal;
      e.id     = vecId;
      e.fwdA   = ea;
      e.fwdB   = eb;
      e.bubble = eBub;
      e.stall  = eSt;
      e.count  = CNT_W'(eCnt);
      expQ.push_back(e);
      vecId++;
   endtask

   // Empty ID slot.
   task automatic idleOp(input logic rstVal, input logic [1:0] ea, input logic [1:0] eb,
                         input logic eBub, input logic eSt, input int eCnt);
      applyStimulus(rstVal, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                    ea, eb, eBub, eSt, eCnt);
   endtask

   // R-type instruction: rd <- rs1 op rs2.
   task automatic addOp(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                        input logic [REG_AW-1:0] rs2, input logic [1:0] ea, input logic [1:0] eb,
                        input logic eBub, input logic eSt, input int eCnt);
      applyStimulus(1'b0, 1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0,
                    ea, eb, eBub, eSt, eCnt);
   endtask

   // Load: rd <- mem[rs1 + imm].
   task automatic lwOp(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                       input logic [1:0] ea, input logic [1:0] eb,
                       input logic eBub, input logic eSt, input int eCnt);
      applyStimulus(1'b0, 1'b1, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0,
                    ea, eb, eBub, eSt, eCnt);
   endtask

   // Directed sequence. Each line's expectation is the DUT output during
   // the cycle in which that line's ID inputs are presented.
   initial begin
      rst        = 1'b1;
      idValid    = 1'b0;
      idRs1      = '0;
      idRs2      = '0;
      idUseRs1   = 1'b0;
      idUseRs2   = 1'b0;
      idRd       = '0;
      idRegwrite = 1'b0;
      idMemread  = 1'b0;
      flush      = 1'b0;

      // reset values, then release, then one idle cycle
      idleOp(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 0);
      idleOp(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 0);
      idleOp(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 0);

      // add x5 ; sub x6,x5,x5 -> both operands from EX/MEM
      addOp(5'd5,  5'd1, 5'd2, 2'b00, 2'b00, 1'b1, 1'b0, 0);
      addOp(5'd6,  5'd5, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 0);
      idleOp(1'b0,             2'b10, 2'b10, 1'b0, 1'b0, 0);

      // add x5 ; nop ; or x7,x1,x5 -> B from MEM/WB
      addOp(5'd5,  5'd1, 5'd2, 2'b00, 2'b00, 1'b1, 1'b0, 0);
      idleOp(1'b0,             2'b00, 2'b00, 1'b0, 1'b0, 0);
      addOp(5'd7,  5'd1, 5'd5, 2'b00, 2'b00, 1'b1, 1'b0, 0);
      idleOp(1'b0,             2'b00, 2'b01, 1'b0, 1'b0, 0);

      // lw x8 ; add x9,x8,x2 -> one stall, bubble, then A from MEM/WB
      lwOp(5'd8,   5'd1,       2'b00, 2'b00, 1'b1, 1'b0, 0);
      addOp(5'd9,  5'd8, 5'd2, 2'b00, 2'b00, 1'b0, 1'b1, 0);
      addOp(5'd9,  5'd8, 5'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1);
      idleOp(1'b0,             2'b01, 2'b00, 1'b0, 1'b0, 1);

      // lw x10 ; add x11,x10,x10 with flush -> no stall, bubble, count held
      lwOp(5'd10,  5'd1,       2'b00, 2'b00, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1,
                    2'b00, 2'b00, 1'b0, 1'b0, 1);
      idleOp(1'b0,             2'b00, 2'b00, 1'b1, 1'b0, 1);

      // producer of x0 ; consumer of x0 -> never forwarded
      addOp(5'd0,  5'd1, 5'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1);
      addOp(5'd12, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
      idleOp(1'b0,             2'b00, 2'b00, 1'b0, 1'b0, 1);

      // add x13 ; add x14 ; sub x15,x14,x13 -> A from EX/MEM, B from MEM/WB
      addOp(5'd13, 5'd1, 5'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1);
      addOp(5'd14, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1);
      addOp(5'd15, 5'd14, 5'd13, 2'b00, 2'b00, 1'b0, 1'b0, 1);
      idleOp(1'b0,             2'b10, 2'b01, 1'b0, 1'b0, 1);

      // add x5 ; add x5 ; consumer reads x5 on A only -> newest producer wins
      addOp(5'd5,  5'd1, 5'd2, 2'b00, 2'b00, 1'b1, 1'b0, 1);
      addOp(5'd5,  5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0,
                    2'b00, 2'b00, 1'b0, 1'b0, 1);
      idleOp(1'b0,             2'b10, 2'b00, 1'b0, 1'b0, 1);

      // reset arrives mid-cycle during a load-use stall
      lwOp(5'd8,   5'd1,       2'b00, 2'b00, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0,
                    2'b00, 2'b00, 1'b1, 1'b0, 0);
      idleOp(1'b1,             2'b00, 2'b00, 1'b1, 1'b0, 0);
      idleOp(1'b0,             2'b00, 2'b00, 1'b1, 1'b0, 0);

      // 20 load-use stalls: counter climbs, then sticks at 15
      for (int k = 0; k < 20; k++) begin
         lwOp(5'd8,  5'd1,       2'b00, 2'b00, 1'b1, 1'b0, (k > 15) ? 15 : k);
         addOp(5'd9, 5'd8, 5'd2, 2'b00, 2'b00, 1'b0, 1'b1, (k > 15) ? 15 : k);
      end
      idleOp(1'b0,             2'b00, 2'b00, 1'b1, 1'b0, 15);

      // let the monitor drain, bounded
      for (int w = 0; w < 10 && expQ.size() > 0; w++) begin
         @(negedge clk);
      end
      @(negedge clk);
      #1;
      assertions++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
